// File: rtl/scarv_cop_bus_pkg.sv
// Shared definitions for the coprocessor memory bridge: FSM state encoding,
// the default response timeout, and store-masking helpers.
package scarv_cop_bus_pkg;

  // Bridge FSM state encoding.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  // Default number of WAIT cycles before a response is synthesised as an error.
  localparam int BUS_TIMEOUT_DEFAULT = 255;

  // Loads never carry write data onto the bus.
  function automatic logic [31:0] store_only_data(input logic wen, input logic [31:0] data);
    return wen ? data : 32'h0;
  endfunction

  // Loads never carry byte enables onto the bus.
  function automatic logic [3:0] store_only_ben(input logic wen, input logic [3:0] ben);
    return wen ? ben : 4'h0;
  endfunction

endpackage

// File: rtl/scarv_cop_mem_bridge_if.sv
// Shared memory bus: single-outstanding request/grant with a separate
// response phase. The bridge is the master, the memory side the slave.
interface scarv_cop_mem_bridge_if;

  logic        bus_req;
  logic        bus_wen;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_ben;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  logic        bus_error;

  modport master (
    output bus_req, bus_wen, bus_addr, bus_wdata, bus_ben,
    input  bus_gnt, bus_rvalid, bus_rdata, bus_error
  );

  modport slave (
    input  bus_req, bus_wen, bus_addr, bus_wdata, bus_ben,
    output bus_gnt, bus_rvalid, bus_rdata, bus_error
  );

endinterface

// File: rtl/scarv_cop_mem_bridge.sv
// Converts the coprocessor load/store unit's hold-until-not-stalled port into
// a registered, single-outstanding bus transaction with a response timeout.
// Captured response data is only visible in the response cycle and is wiped
// afterwards so operands do not linger in the bridge.
module scarv_cop_mem_bridge
  import scarv_cop_bus_pkg::*;
#(
  parameter int TO_W    = 8,
  parameter int TIMEOUT = BUS_TIMEOUT_DEFAULT
) (
  input  logic        g_clk,
  input  logic        g_resetn,

  input  logic        cop_mem_cen,
  input  logic        cop_mem_wen,
  input  logic [31:0] cop_mem_addr,
  input  logic [31:0] cop_mem_wdata,
  input  logic [3:0]  cop_mem_ben,
  output logic [31:0] cop_mem_rdata,
  output logic        cop_mem_stall,
  output logic        cop_mem_error,

  scarv_cop_mem_bridge_if.master bus
);

  localparam logic [TO_W-1:0] TO_MAX   = '1;
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT);
  localparam bit              TO_EN    = (TIMEOUT != 0);

  logic [1:0]      state_reg,     state_next;
  logic            req_wen_reg,   req_wen_next;
  logic [31:0]     req_addr_reg,  req_addr_next;
  logic [31:0]     req_wdata_reg, req_wdata_next;
  logic [3:0]      req_ben_reg,   req_ben_next;
  logic [31:0]     rsp_rdata_reg, rsp_rdata_next;
  logic            rsp_error_reg, rsp_error_next;
  logic [TO_W-1:0] to_cnt_reg,    to_cnt_next;

  logic [TO_W-1:0] to_cnt_inc;
  logic            to_expired;
  logic            in_req;
  logic            in_resp;

  // Saturating increment; expiry is judged on the value the counter is about to reach.
  always_comb begin
    to_cnt_inc = (to_cnt_reg == TO_MAX) ? to_cnt_reg : to_cnt_reg + 1'b1;
    to_expired = TO_EN && (to_cnt_inc == TO_LIMIT);
  end

  // Next-state and register-update decode for the transaction FSM.
  always_comb begin
    state_next     = state_reg;
    req_wen_next   = req_wen_reg;
    req_addr_next  = req_addr_reg;
    req_wdata_next = req_wdata_reg;
    req_ben_next   = req_ben_reg;
    rsp_rdata_next = rsp_rdata_reg;
    rsp_error_next = rsp_error_reg;
    to_cnt_next    = to_cnt_reg;

    case (state_reg)
      ST_IDLE: begin
        if (cop_mem_cen) begin
          req_wen_next   = cop_mem_wen;
          req_addr_next  = cop_mem_addr;
          req_wdata_next = store_only_data(cop_mem_wen, cop_mem_wdata);
          req_ben_next   = store_only_ben(cop_mem_wen, cop_mem_ben);
          state_next     = ST_REQ;
        end
      end

      ST_REQ: begin
        // Any rvalid seen here belongs to an abandoned transaction or is a
        // protocol violation; only the grant matters.
        if (bus.bus_gnt) begin
          to_cnt_next = '0;
          state_next  = ST_WAIT;
        end
      end

      ST_WAIT: begin
        to_cnt_next = to_cnt_inc;
        if (bus.bus_rvalid) begin
          rsp_rdata_next = req_wen_reg ? 32'h0 : bus.bus_rdata;
          rsp_error_next = bus.bus_error;
          state_next     = ST_RESP;
        end else if (to_expired) begin
          rsp_rdata_next = 32'h0;
          rsp_error_next = 1'b1;
          state_next     = ST_RESP;
        end
      end

      ST_RESP: begin
        // The response is presented for exactly this cycle, then wiped.
        rsp_rdata_next = 32'h0;
        rsp_error_next = 1'b0;
        if (cop_mem_cen) begin
          // Back-to-back: the next request skips IDLE entirely.
          req_wen_next   = cop_mem_wen;
          req_addr_next  = cop_mem_addr;
          req_wdata_next = store_only_data(cop_mem_wen, cop_mem_wdata);
          req_ben_next   = store_only_ben(cop_mem_wen, cop_mem_ben);
          state_next     = ST_REQ;
        end else begin
          req_wen_next   = 1'b0;
          req_addr_next  = 32'h0;
          req_wdata_next = 32'h0;
          req_ben_next   = 4'h0;
          state_next     = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State and data registers, cleared asynchronously so no secret survives a reset.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_reg     <= ST_IDLE;
      req_wen_reg   <= 1'b0;
      req_addr_reg  <= 32'h0;
      req_wdata_reg <= 32'h0;
      req_ben_reg   <= 4'h0;
      rsp_rdata_reg <= 32'h0;
      rsp_error_reg <= 1'b0;
      to_cnt_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      req_wen_reg   <= req_wen_next;
      req_addr_reg  <= req_addr_next;
      req_wdata_reg <= req_wdata_next;
      req_ben_reg   <= req_ben_next;
      rsp_rdata_reg <= rsp_rdata_next;
      rsp_error_reg <= rsp_error_next;
      to_cnt_reg    <= to_cnt_next;
    end
  end

  // Outputs are decoded purely from state and registers; nothing flows through combinationally.
  always_comb begin
    in_req  = (state_reg == ST_REQ);
    in_resp = (state_reg == ST_RESP);
  end

  assign bus.bus_req    = in_req;
  assign bus.bus_wen    = in_req & req_wen_reg;
  assign bus.bus_addr   = in_req ? req_addr_reg  : 32'h0;
  assign bus.bus_wdata  = in_req ? req_wdata_reg : 32'h0;
  assign bus.bus_ben    = in_req ? req_ben_reg   : 4'h0;

  assign cop_mem_stall  = ~in_resp;
  assign cop_mem_rdata  = in_resp ? rsp_rdata_reg : 32'h0;
  assign cop_mem_error  = in_resp & rsp_error_reg;

endmodule

// File: tb/tb_scarv_cop_mem_bridge.sv
// Self-checking bench for scarv_cop_mem_bridge: a table of directed
// transactions, hand-written multi-cycle sequences, and random transactions
// checked against a transaction-level model.
module tb_scarv_cop_mem_bridge;

  localparam int TB_TIMEOUT = 4;

  logic        g_clk;
  logic        g_resetn;
  logic        cop_mem_cen;
  logic        cop_mem_wen;
  logic [31:0] cop_mem_addr;
  logic [31:0] cop_mem_wdata;
  logic [3:0]  cop_mem_ben;
  logic [31:0] cop_mem_rdata;
  logic        cop_mem_stall;
  logic        cop_mem_error;

  scarv_cop_mem_bridge_if bus_if ();

  scarv_cop_mem_bridge #(.TO_W(8), .TIMEOUT(TB_TIMEOUT)) dut (
    .g_clk         (g_clk),
    .g_resetn      (g_resetn),
    .cop_mem_cen   (cop_mem_cen),
    .cop_mem_wen   (cop_mem_wen),
    .cop_mem_addr  (cop_mem_addr),
    .cop_mem_wdata (cop_mem_wdata),
    .cop_mem_ben   (cop_mem_ben),
    .cop_mem_rdata (cop_mem_rdata),
    .cop_mem_stall (cop_mem_stall),
    .cop_mem_error (cop_mem_error),
    .bus           (bus_if)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  ben;
    int          gd;        // cycles bus_req is held before grant
    int          rv;        // WAIT cycles before rvalid (>= TIMEOUT means never in time)
    logic [31:0] rdata;
    logic        berr;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [31:0] exp_bwdata;
    logic [3:0]  exp_bben;
    int          exp_lat;   // cycles from cen cycle to response cycle
  } vec_t;

  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    cop_mem_cen   = 1'b0;
    cop_mem_wen   = 1'b0;
    cop_mem_addr  = 32'h0;
    cop_mem_wdata = 32'h0;
    cop_mem_ben   = 4'h0;
    bus_if.bus_gnt    = 1'b0;
    bus_if.bus_rvalid = 1'b0;
    bus_if.bus_rdata  = 32'h0;
    bus_if.bus_error  = 1'b0;
  endtask

  // Transaction-level reference: at most TIMEOUT WAIT cycles, loads only return data.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    bit   timed_out;
    r = v;
    timed_out    = (v.rv >= TB_TIMEOUT);
    r.exp_rdata  = (timed_out || v.wen) ? 32'h0 : v.rdata;
    r.exp_err    = timed_out ? 1'b1 : v.berr;
    r.exp_bwdata = v.wen ? v.wdata : 32'h0;
    r.exp_bben   = v.wen ? v.ben : 4'h0;
    r.exp_lat    = 1 + v.gd + (timed_out ? (1 + TB_TIMEOUT) : (2 + v.rv));
    return r;
  endfunction

  // One complete transaction from IDLE with a reactive bus responder.
  task automatic run_txn(input vec_t v, input string tag);
    int          cyc, req_seen, gnt_cyc, lat;
    bit          granted, done, stable;
    logic        s_wen;
    logic [31:0] s_addr, s_wdata, r_rdata;
    logic [3:0]  s_ben;
    logic        r_err;
    s_wen = 1'b0; s_addr = 32'h0; s_wdata = 32'h0; s_ben = 4'h0;
    r_rdata = 32'h0; r_err = 1'b0;
    cop_mem_cen   = 1'b1;
    cop_mem_wen   = v.wen;
    cop_mem_addr  = v.addr;
    cop_mem_wdata = v.wdata;
    cop_mem_ben   = v.ben;
    bus_if.bus_gnt    = 1'b0;
    bus_if.bus_rvalid = 1'b0;
    tick();
    cyc = 1; req_seen = 0; gnt_cyc = 0; lat = -1;
    granted = 1'b0; done = 1'b0; stable = 1'b1;
    while (!done && cyc < 60) begin
      bus_if.bus_gnt    = 1'b0;
      bus_if.bus_rvalid = 1'b0;
      bus_if.bus_rdata  = $urandom;
      bus_if.bus_error  = 1'($urandom_range(0, 1));
      if (!cop_mem_stall) begin
        lat     = cyc;
        r_rdata = cop_mem_rdata;
        r_err   = cop_mem_error;
        cop_mem_cen = 1'b0;
        done = 1'b1;
      end else begin
        // Upstream churn while the transaction is in flight must be ignored.
        cop_mem_cen   = 1'($urandom_range(0, 1));
        cop_mem_wen   = 1'($urandom_range(0, 1));
        cop_mem_addr  = $urandom;
        cop_mem_wdata = $urandom;
        cop_mem_ben   = 4'($urandom_range(0, 15));
        if (bus_if.bus_req) begin
          if (req_seen == 0) begin
            s_wen = bus_if.bus_wen; s_addr = bus_if.bus_addr;
            s_wdata = bus_if.bus_wdata; s_ben = bus_if.bus_ben;
          end else if (bus_if.bus_wen !== s_wen || bus_if.bus_addr !== s_addr ||
                       bus_if.bus_wdata !== s_wdata || bus_if.bus_ben !== s_ben) begin
            stable = 1'b0;
          end
          if (req_seen == v.gd) begin
            bus_if.bus_gnt = 1'b1;
            granted = 1'b1;
            gnt_cyc = cyc;
          end else begin
            bus_if.bus_rvalid = 1'($urandom_range(0, 1));
          end
          req_seen++;
        end else if (granted && (cyc - gnt_cyc - 1) == v.rv) begin
          bus_if.bus_rvalid = 1'b1;
          bus_if.bus_rdata  = v.rdata;
          bus_if.bus_error  = v.berr;
        end
      end
      tick();
      cyc++;
    end
    bus_if.bus_gnt    = 1'b0;
    bus_if.bus_rvalid = 1'b0;
    check({tag, " latency"},    32'(lat),      32'(v.exp_lat));
    check({tag, " rdata"},      r_rdata,       v.exp_rdata);
    check({tag, " error"},      32'(r_err),    32'(v.exp_err));
    check({tag, " req_cycles"}, 32'(req_seen), 32'(v.gd + 1));
    check({tag, " bus_wen"},    32'(s_wen),    32'(v.wen));
    check({tag, " bus_addr"},   s_addr,        v.addr);
    check({tag, " bus_wdata"},  s_wdata,       v.exp_bwdata);
    check({tag, " bus_ben"},    32'(s_ben),    32'(v.exp_bben));
    check({tag, " fields_stable"}, 32'(stable), 32'd1);
    check({tag, " post stall"}, 32'(cop_mem_stall), 32'd1);
    check({tag, " post rdata"}, cop_mem_rdata, 32'h0);
    check({tag, " post error"}, 32'(cop_mem_error), 32'd0);
    $display("txn %s wen=%0d addr=0x%08h gd=%0d rv=%0d rdata=0x%08h err=%0d lat=%0d",
             tag, v.wen, v.addr, v.gd, v.rv, r_rdata, r_err, lat);
  endtask

  // Four loads, each next request issued in the previous response cycle.
  task automatic run_b2b();
    logic [31:0] a [4];
    logic [31:0] d [4];
    int          k, cyc, req_seen, gnt_cyc, grants;
    bit          granted, chk_req;
    for (int i = 0; i < 4; i++) begin
      a[i] = 32'h0000_4000 + 32'(i * 4);
      d[i] = $urandom;
    end
    cop_mem_cen = 1'b1; cop_mem_wen = 1'b0; cop_mem_addr = a[0];
    cop_mem_wdata = 32'h0; cop_mem_ben = 4'h0;
    tick();
    k = 0; cyc = 1; req_seen = 0; gnt_cyc = 0; grants = 0;
    granted = 1'b0; chk_req = 1'b0;
    while (k < 4 && cyc < 100) begin
      if (chk_req) begin
        check($sformatf("b2b%0d no idle bus_req", k), 32'(bus_if.bus_req), 32'd1);
        check($sformatf("b2b%0d bus_addr", k), bus_if.bus_addr, a[k]);
        chk_req = 1'b0;
      end
      bus_if.bus_gnt    = 1'b0;
      bus_if.bus_rvalid = 1'b0;
      if (!cop_mem_stall) begin
        check($sformatf("b2b%0d rdata", k), cop_mem_rdata, d[k]);
        check($sformatf("b2b%0d error", k), 32'(cop_mem_error), 32'd0);
        $display("txn b2b%0d addr=0x%08h rdata=0x%08h cycle=%0d", k, a[k], cop_mem_rdata, cyc);
        k++;
        if (k < 4) begin
          cop_mem_cen = 1'b1; cop_mem_addr = a[k]; chk_req = 1'b1;
        end else begin
          cop_mem_cen = 1'b0;
        end
        req_seen = 0; granted = 1'b0;
      end else begin
        cop_mem_cen = 1'b0;
        if (bus_if.bus_req) begin
          if (req_seen == (k % 2)) begin
            bus_if.bus_gnt = 1'b1; granted = 1'b1; gnt_cyc = cyc; grants++;
          end
          req_seen++;
        end else if (granted && (cyc - gnt_cyc - 1) == k) begin
          bus_if.bus_rvalid = 1'b1;
          bus_if.bus_rdata  = d[k];
          bus_if.bus_error  = 1'b0;
        end
      end
      tick();
      cyc++;
    end
    bus_if.bus_gnt = 1'b0; bus_if.bus_rvalid = 1'b0;
    check("b2b responses", 32'(k), 32'd4);
    check("b2b grants", 32'(grants), 32'd4);
    check("b2b final stall", 32'(cop_mem_stall), 32'd1);
  endtask

  // Start a load and stop it in REQ (stop_in_wait=0) or WAIT (1), then reset between edges.
  task automatic reset_mid_txn(input bit stop_in_wait, input string tag);
    cop_mem_cen = 1'b1; cop_mem_wen = 1'b0; cop_mem_addr = 32'h0000_0200;
    tick();
    cop_mem_cen = 1'b0;
    check({tag, " pre bus_req"}, 32'(bus_if.bus_req), 32'd1);
    if (stop_in_wait) begin
      bus_if.bus_gnt = 1'b1;
      tick();
      bus_if.bus_gnt = 1'b0;
      check({tag, " pre stall"}, 32'(cop_mem_stall), 32'd1);
    end
    #2;
    g_resetn = 1'b0;
    #1;
    check({tag, " stall"},    32'(cop_mem_stall),  32'd1);
    check({tag, " bus_req"},  32'(bus_if.bus_req), 32'd0);
    check({tag, " bus_addr"}, bus_if.bus_addr,     32'h0);
    check({tag, " rdata"},    cop_mem_rdata,       32'h0);
    tick();
    tick();
    #2;
    g_resetn = 1'b1;
    tick();
    check({tag, " idle after release"}, 32'(bus_if.bus_req), 32'd0);
    $display("txn %s reset applied mid-transaction", tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl [8];
    vec_t rv;

    // wen addr wdata ben gd rv rdata berr | exp_rdata exp_err exp_bwdata exp_bben exp_lat
    tbl[0] = '{1'b0, 32'h0000_0100, 32'h0,          4'h0, 0, 0,  32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'h0,          4'h0, 3};
    tbl[1] = '{1'b1, 32'h0000_0104, 32'h00AB_0000,  4'h4, 3, 0,  32'h1234_5678, 1'b0, 32'h0,         1'b0, 32'h00AB_0000,  4'h4, 6};
    tbl[2] = '{1'b0, 32'h0000_0108, 32'hFFFF_FFFF,  4'hF, 1, 2,  32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 1'b0, 32'h0,          4'h0, 6};
    tbl[3] = '{1'b0, 32'h0000_010C, 32'h0,          4'h0, 0, 1,  32'h0000_0055, 1'b1, 32'h0000_0055, 1'b1, 32'h0,          4'h0, 4};
    tbl[4] = '{1'b0, 32'h0000_0110, 32'h0,          4'h0, 0, 99, 32'h7777_7777, 1'b0, 32'h0,         1'b1, 32'h0,          4'h0, 6};
    tbl[5] = '{1'b0, 32'h0000_0114, 32'h0,          4'h0, 2, 3,  32'h0000_A5A5, 1'b0, 32'h0000_A5A5, 1'b0, 32'h0,          4'h0, 8};
    tbl[6] = '{1'b1, 32'h0000_0118, 32'h1111_2222,  4'h3, 0, 0,  32'h9999_9999, 1'b1, 32'h0,         1'b1, 32'h1111_2222,  4'h3, 3};
    tbl[7] = '{1'b1, 32'h0000_011C, 32'h3333_4444,  4'hF, 2, 99, 32'h0,         1'b0, 32'h0,         1'b1, 32'h3333_4444,  4'hF, 8};

    idle_inputs();
    g_resetn = 1'b0;
    #1;
    check("reset stall",     32'(cop_mem_stall),   32'd1);
    check("reset rdata",     cop_mem_rdata,        32'h0);
    check("reset error",     32'(cop_mem_error),   32'd0);
    check("reset bus_req",   32'(bus_if.bus_req),  32'd0);
    check("reset bus_addr",  bus_if.bus_addr,      32'h0);
    check("reset bus_wdata", bus_if.bus_wdata,     32'h0);
    tick();
    tick();
    @(negedge g_clk);
    g_resetn = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      run_txn(tbl[i], $sformatf("vec%0d", i));
    end

    // Timeout, then a late rvalid for the abandoned transaction arrives while IDLE.
    run_txn(tbl[4], "timeout");
    bus_if.bus_rvalid = 1'b1;
    bus_if.bus_rdata  = 32'hBADB_AD00;
    bus_if.bus_error  = 1'b1;
    tick();
    tick();
    check("stray stall",   32'(cop_mem_stall),  32'd1);
    check("stray rdata",   cop_mem_rdata,       32'h0);
    check("stray error",   32'(cop_mem_error),  32'd0);
    check("stray bus_req", 32'(bus_if.bus_req), 32'd0);
    bus_if.bus_rvalid = 1'b0;
    bus_if.bus_error  = 1'b0;
    $display("txn stray rvalid in IDLE");
    run_txn(tbl[0], "after_stray");

    run_b2b();

    reset_mid_txn(1'b0, "rst_in_req");
    reset_mid_txn(1'b1, "rst_in_wait");
    run_txn(tbl[0], "after_reset");

    for (int i = 0; i < 30; i++) begin
      rv.wen   = 1'($urandom_range(0, 1));
      rv.addr  = $urandom & 32'hFFFF_FFFC;
      rv.wdata = $urandom;
      rv.ben   = 4'($urandom_range(0, 15));
      rv.gd    = int'($urandom_range(0, 3));
      rv.rv    = int'($urandom_range(0, 5));
      rv.rdata = $urandom;
      rv.berr  = 1'($urandom_range(0, 1));
      rv = model(rv);
      run_txn(rv, $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
